// File: rtl/cmos_dvp_emitter.sv
// OV7670-style DVP transmitter: VSYNC/HREF/PCLK plus an RGB565 byte stream, high byte first.
// Pixels come from an external request/data port or from a built-in test-pattern generator.
module cmos_dvp_emitter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 144,
   parameter int VS_W     = 1568,
   parameter int V_BP     = 13328,
   parameter int V_FP     = 7840
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iEN,
   input  logic [1:0]  iMODE,
   input  logic [15:0] iPIX_DATA,
   output logic        oPIX_REQ,
   output logic        CMOS_PCLK,
   output logic        CMOS_VSYNC,
   output logic        CMOS_HREF,
   output logic [7:0]  CMOS_DATA,
   output logic [7:0]  oFRAME_CNT,
   output logic        oFRAME_DONE,
   output logic        oBUSY
);
   // state | meaning
   // IDLE  | waiting for iEN, all outputs low
   // VS    | VSYNC high for VS_W cycles
   // VBP   | vertical back porch, V_BP cycles
   // ACT   | active line, HREF high for 2*H_ACTIVE byte cycles
   // HBLK  | horizontal blanking between lines, H_BLANK cycles
   // VFP   | vertical front porch, frame done on its last cycle
   typedef enum logic [2:0] {IDLE, VS, VBP, ACT, HBLK, VFP} state_t;

   localparam int XW    = $clog2(H_ACTIVE);
   localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int M1    = (VS_W > V_BP) ? VS_W : V_BP;
   localparam int M2    = (H_BLANK > V_FP) ? H_BLANK : V_FP;
   localparam int MAXL  = (M1 > M2) ? M1 : M2;
   localparam int CW    = (MAXL > 1) ? $clog2(MAXL) : 1;
   localparam int BAR_W = H_ACTIVE / 8;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic            ph_q, ph_d;
   logic [1:0]      mode_q, mode_d;
   logic [7:0]      fid_q, fid_d;
   logic [15:0]     ext_q, ext_d;
   logic            vsync_q, vsync_d;
   logic            href_q, href_d;
   logic [7:0]      data_q, data_d;
   logic            req_q, req_d;
   logic            done_q, done_d;
   logic [7:0]      fcnt_q, fcnt_d;
   logic            busy_q, busy_d;
   logic            start;
   logic [2:0]      bar;
   logic [15:0]     pix;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      ph_d    = ph_q;
      mode_d  = mode_q;
      fid_d   = fid_q;
      fcnt_d  = fcnt_q;
      ext_d   = req_q ? iPIX_DATA : ext_q;
      start   = 1'b0;
      case (state_q)
         IDLE: start = iEN;
         VS: begin
            if (cnt_q == '0) begin
               state_d = VBP;
               cnt_d   = CW'(V_BP - 1);
            end else cnt_d = cnt_q - 1'b1;
         end
         VBP, HBLK: begin
            if (cnt_q == '0) state_d = ACT;
            else cnt_d = cnt_q - 1'b1;
         end
         ACT: begin
            ph_d = ~ph_q;
            if (ph_q) begin
               if (x_q == XW'(H_ACTIVE - 1)) begin
                  x_d = '0;
                  if (y_q == YW'(V_ACTIVE - 1)) begin
                     state_d = VFP;
                     cnt_d   = CW'(V_FP - 1);
                  end else begin
                     state_d = HBLK;
                     cnt_d   = CW'(H_BLANK - 1);
                     y_d     = y_q + 1'b1;
                  end
               end else x_d = x_q + 1'b1;
            end
         end
         VFP: begin
            if (cnt_q == '0) begin
               if (iEN) start = 1'b1;
               else state_d = IDLE;
            end else cnt_d = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // fcnt_q already holds the post-increment count when VFP ends
      if (start) begin
         state_d = VS;
         cnt_d   = CW'(VS_W - 1);
         x_d     = '0;
         y_d     = '0;
         ph_d    = 1'b0;
         mode_d  = iMODE;
         fid_d   = fcnt_q;
      end
      done_d = (state_d == VFP) && (cnt_d == '0);
      if (done_d) fcnt_d = fcnt_q + 1'b1;

      bar = 3'(32'(x_d) / BAR_W);
      case (mode_d)
         2'b00: pix = ext_d;
         2'b01: begin
            case (bar)
               3'd0:    pix = 16'hFFFF;
               3'd1:    pix = 16'hFFE0;
               3'd2:    pix = 16'h07FF;
               3'd3:    pix = 16'h07E0;
               3'd4:    pix = 16'hF81F;
               3'd5:    pix = 16'hF800;
               3'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'b10:   pix = {8'(y_d), 8'(x_d)};
         default: pix = {8'hA5, fid_d};
      endcase

      vsync_d = (state_d == VS);
      href_d  = (state_d == ACT);
      data_d  = href_d ? (ph_d ? pix[7:0] : pix[15:8]) : 8'h00;
      req_d   = (mode_d == 2'b00) &&
                ((((state_d == VBP) || (state_d == HBLK)) && (cnt_d == '0)) ||
                 ((state_d == ACT) && ph_d && (x_d != XW'(H_ACTIVE - 1))));
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         ph_q    <= 1'b0;
         mode_q  <= 2'b00;
         fid_q   <= 8'h00;
         ext_q   <= 16'h0000;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= 8'h00;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         fcnt_q  <= 8'h00;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ph_q    <= ph_d;
         mode_q  <= mode_d;
         fid_q   <= fid_d;
         ext_q   <= ext_d;
         vsync_q <= vsync_d;
         href_q  <= href_d;
         data_q  <= data_d;
         req_q   <= req_d;
         done_q  <= done_d;
         fcnt_q  <= fcnt_d;
         busy_q  <= busy_d;
      end
   end

   assign CMOS_PCLK   = iCLK;
   assign CMOS_VSYNC  = vsync_q;
   assign CMOS_HREF   = href_q;
   assign CMOS_DATA   = data_q;
   assign oPIX_REQ    = req_q;
   assign oFRAME_DONE = done_q;
   assign oFRAME_CNT  = fcnt_q;
   assign oBUSY       = busy_q;
endmodule

// File: tb/tb_cmos_dvp_emitter.sv
// Bench for cmos_dvp_emitter: every cycle of each frame is compared against a
// timeline model built from the frame geometry and the pixel-source rules.
module tb_cmos_dvp_emitter;
   localparam int H_ACTIVE = 8;
   localparam int V_ACTIVE = 2;
   localparam int H_BLANK  = 3;
   localparam int VS_W     = 2;
   localparam int V_BP     = 2;
   localparam int V_FP     = 3;
   localparam int LEN      = VS_W + V_BP + V_ACTIVE*2*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_FP;
   localparam int NPIX     = H_ACTIVE * V_ACTIVE;

   logic        iCLK;
   logic        iRST_N;
   logic        iEN;
   logic [1:0]  iMODE;
   logic [15:0] iPIX_DATA;
   logic        oPIX_REQ;
   logic        CMOS_PCLK;
   logic        CMOS_VSYNC;
   logic        CMOS_HREF;
   logic [7:0]  CMOS_DATA;
   logic [7:0]  oFRAME_CNT;
   logic        oFRAME_DONE;
   logic        oBUSY;

   int          total;
   int          bad;
   logic [7:0]  fcnt_exp;
   logic [15:0] ext_vals [NPIX];
   logic [15:0] bars [8];
   logic [1:0]  m, nm;

   cmos_dvp_emitter #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
      .VS_W(VS_W), .V_BP(V_BP), .V_FP(V_FP)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iMODE(iMODE), .iPIX_DATA(iPIX_DATA),
      .oPIX_REQ(oPIX_REQ), .CMOS_PCLK(CMOS_PCLK), .CMOS_VSYNC(CMOS_VSYNC),
      .CMOS_HREF(CMOS_HREF), .CMOS_DATA(CMOS_DATA), .oFRAME_CNT(oFRAME_CNT),
      .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [15:0] pix_of(input logic [1:0] mode, input int l, input int k,
                                           input logic [7:0] fid);
      case (mode)
         2'b00:   return ext_vals[l*H_ACTIVE + k];
         2'b01:   return bars[k / (H_ACTIVE/8)];
         2'b10:   return {8'(l), 8'(k)};
         default: return {8'hA5, fid};
      endcase
   endfunction

   // Walk the frame timeline segment by segment to find what cycle `cyc` should show.
   function automatic void model(input int cyc, input logic [1:0] mode, input logic [7:0] fid,
                                 output logic vs, output logic href, output logic req,
                                 output logic [7:0] data);
      int c;
      logic [15:0] p;
      c = cyc; vs = 1'b0; href = 1'b0; req = 1'b0; data = 8'h00;
      if (c < VS_W) begin vs = 1'b1; return; end
      c -= VS_W;
      if (c < V_BP) begin req = (mode == 2'b00) && (c == V_BP-1); return; end
      c -= V_BP;
      for (int l = 0; l < V_ACTIVE; l++) begin
         if (c < 2*H_ACTIVE) begin
            p    = pix_of(mode, l, c/2, fid);
            href = 1'b1;
            data = (c % 2 == 1) ? p[7:0] : p[15:8];
            req  = (mode == 2'b00) && (c % 2 == 1) && (c/2 != H_ACTIVE-1);
            return;
         end
         c -= 2*H_ACTIVE;
         if (l < V_ACTIVE-1) begin
            if (c < H_BLANK) begin req = (mode == 2'b00) && (c == H_BLANK-1); return; end
            c -= H_BLANK;
         end
      end
   endfunction

   task automatic run_frame(input logic [1:0] mode, input bit rnd_ext, input int drop_at,
                            input int stop_at, input logic next_en, input logic [1:0] next_mode);
      logic [7:0] fid, e_data, e_fcnt;
      logic       e_vs, e_href, e_req, e_done;
      int         ridx;
      fid  = fcnt_exp;
      ridx = 0;
      for (int i = 0; i < NPIX; i++)
         ext_vals[i] = rnd_ext ? 16'($urandom) : 16'h1234 + 16'(i);
      for (int c = 0; c < stop_at; c++) begin
         @(negedge iCLK);
         model(c, mode, fid, e_vs, e_href, e_req, e_data);
         e_done = (c == LEN-1);
         e_fcnt = e_done ? fcnt_exp + 8'd1 : fcnt_exp;
         chk("vsync", c, 16'(CMOS_VSYNC), 16'(e_vs));
         chk("href",  c, 16'(CMOS_HREF),  16'(e_href));
         chk("data",  c, 16'(CMOS_DATA),  16'(e_data));
         chk("req",   c, 16'(oPIX_REQ),   16'(e_req));
         chk("done",  c, 16'(oFRAME_DONE), 16'(e_done));
         chk("fcnt",  c, 16'(oFRAME_CNT), 16'(e_fcnt));
         chk("busy",  c, 16'(oBUSY),      16'h0001);
         if (oPIX_REQ === 1'b1) begin
            if (ridx < NPIX) iPIX_DATA = ext_vals[ridx];
            ridx++;
         end
         if (c == 5) iMODE = 2'($urandom);
         if (c == drop_at) iEN = 1'b0;
         if (c == LEN-1) begin iEN = next_en; iMODE = next_mode; end
      end
      if (stop_at >= LEN) begin
         fcnt_exp = fcnt_exp + 8'd1;
         chk("req_count", mode, 16'(ridx), (mode == 2'b00) ? 16'(NPIX) : 16'h0000);
      end
   endtask

   task automatic check_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge iCLK);
         chk("idle_vsync", i, 16'(CMOS_VSYNC), 16'h0000);
         chk("idle_href",  i, 16'(CMOS_HREF),  16'h0000);
         chk("idle_data",  i, 16'(CMOS_DATA),  16'h0000);
         chk("idle_req",   i, 16'(oPIX_REQ),   16'h0000);
         chk("idle_done",  i, 16'(oFRAME_DONE), 16'h0000);
         chk("idle_busy",  i, 16'(oBUSY),      16'h0000);
         chk("idle_fcnt",  i, 16'(oFRAME_CNT), 16'(fcnt_exp));
         chk("pclk",       i, 16'(CMOS_PCLK),  16'(iCLK));
      end
   endtask

   task automatic check_reset_values(input int tagc);
      chk("rst_vsync", tagc, 16'(CMOS_VSYNC), 16'h0000);
      chk("rst_href",  tagc, 16'(CMOS_HREF),  16'h0000);
      chk("rst_data",  tagc, 16'(CMOS_DATA),  16'h0000);
      chk("rst_req",   tagc, 16'(oPIX_REQ),   16'h0000);
      chk("rst_done",  tagc, 16'(oFRAME_DONE), 16'h0000);
      chk("rst_fcnt",  tagc, 16'(oFRAME_CNT), 16'h0000);
      chk("rst_busy",  tagc, 16'(oBUSY),      16'h0000);
   endtask

   initial begin
      bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
      bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
      total = 0; bad = 0; fcnt_exp = 8'h00;
      iRST_N = 1'b0; iEN = 1'b0; iMODE = 2'b00; iPIX_DATA = 16'h0000;
      #1;
      check_reset_values(0);
      #20;
      @(negedge iCLK);
      iRST_N = 1'b1;
      check_idle(3);

      // colour bars, iEN dropped mid-ACT: frame must still complete, then idle
      iMODE = 2'b01; iEN = 1'b1;
      run_frame(2'b01, 1'b0, 10, LEN, 1'b0, 2'b00);
      check_idle(4);

      // external (1234+n), external random, gradient, then a bars frame cut by reset in HBLK
      iMODE = 2'b00; iEN = 1'b1;
      run_frame(2'b00, 1'b0, -1, LEN, 1'b1, 2'b00);
      run_frame(2'b00, 1'b1, -1, LEN, 1'b1, 2'b10);
      run_frame(2'b10, 1'b0, -1, LEN, 1'b1, 2'b01);
      run_frame(2'b01, 1'b0, -1, VS_W + V_BP + 2*H_ACTIVE + 1, 1'b1, 2'b01);
      #2;
      iRST_N = 1'b0;
      #1;
      check_reset_values(1);
      @(negedge iCLK);
      iRST_N = 1'b1; fcnt_exp = 8'h00; iMODE = 2'b11; iEN = 1'b1;

      // frame-id over three back-to-back frames from a fresh counter
      run_frame(2'b11, 1'b0, -1, LEN, 1'b1, 2'b11);
      run_frame(2'b11, 1'b0, -1, LEN, 1'b1, 2'b11);
      run_frame(2'b11, 1'b0, -1, LEN, 1'b0, 2'b00);
      check_idle(4);

      // random source modes chained back to back with random external data
      m = 2'($urandom); iMODE = m; iEN = 1'b1;
      for (int f = 0; f < 3; f++) begin
         nm = 2'($urandom);
         run_frame(m, 1'b1, -1, LEN, (f < 2) ? 1'b1 : 1'b0, nm);
         m = nm;
      end
      check_idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cmos_dvp_emitter.md
Name: cmos_dvp_emitter

Overview:
- Transmit side of the OV7670-style DVP link: produces VSYNC, HREF, PCLK and 8-bit RGB565 byte stream (high byte first) exactly as the sensor does.
- Drives the capture path in simulation/loopback and acts as an on-board test-pattern source when no camera is fitted.
- Pixels come from an external request/data port or an internal pattern generator.
- Frame counter and frame-done pulse are provided for FPS checks.

Parameters:
- H_ACTIVE, 640, pixels per line (HREF high for 2*H_ACTIVE cycles); must be a multiple of 8.
- V_ACTIVE, 480, lines per frame.
- H_BLANK, 144, HREF-low cycles between lines; must be >= 1.
- VS_W, 1568, VSYNC-high cycles per frame; must be >= 1.
- V_BP, 13328, cycles from VSYNC fall to first HREF rise; must be >= 1.
- V_FP, 7840, cycles from last HREF fall to frame end; must be >= 1.

Ports:
- iCLK  in  1  pixel clock, 25 MHz; one byte per cycle.
- iRST_N  in  1  asynchronous active-low reset.
- iEN  in  1  frame generation enable.
- iMODE  in  2  pixel source: 00 external, 01 colour bars, 10 coordinate gradient, 11 frame-id.
- iPIX_DATA  in  16  external RGB565 pixel; sampled on the iCLK edge ending an oPIX_REQ cycle.
- oPIX_REQ  out  1  external pixel request (mode 00 only).
- CMOS_PCLK  out  1  equals iCLK (continuous assign).
- CMOS_VSYNC  out  1  high = vertical sync/blanking.
- CMOS_HREF  out  1  high = active line bytes.
- CMOS_DATA  out  8  byte stream.
- oFRAME_CNT  out  8  completed frames, wraps 255->0.
- oFRAME_DONE  out  1  one-cycle pulse at frame end.
- oBUSY  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: all outputs except CMOS_PCLK are registered on iCLK rising edge. Reset values: VSYNC=0, HREF=0, DATA=0, oPIX_REQ=0, oFRAME_CNT=0, oFRAME_DONE=0, oBUSY=0, state=IDLE.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); no partial line completion.
- State machine:
  - IDLE: outputs low. Moves to VS on the cycle after iEN is sampled high. iMODE is latched at this transition.
  - VS: VSYNC=1 for VS_W cycles, then VBP.
  - VBP: all low for V_BP cycles, then ACT.
  - ACT: HREF=1 for 2*H_ACTIVE cycles. Byte 2k = pixel k [15:8]; byte 2k+1 = pixel k [7:0]. Then HBLK, or VFP after line V_ACTIVE-1.
  - HBLK: HREF=0 and DATA=0 for H_BLANK cycles, then ACT for the next line.
  - VFP: all low for V_FP cycles. On the last cycle: oFRAME_DONE=1 and oFRAME_CNT increments. Next state is VS if iEN=1 (iMODE re-latched), else IDLE.
- iEN low mid-frame: the current frame completes unchanged.
- Frame length (cycles) = VS_W + V_BP + V_ACTIVE*2*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_FP.
- DATA outside ACT is 8'h00.
- Internal counters: x (pixel 0..H_ACTIVE-1), y (line 0..V_ACTIVE-1), byte phase, phase-length counter. All are zeroed on entry to VS.
- External mode (00):
  - oPIX_REQ is high for one cycle before each pixel's high-byte cycle: the last VBP/HBLK cycle before each line, and each low-byte cycle except the line's last.
  - The sampled iPIX_DATA is emitted on the next two cycles.
  - No backpressure: data is taken unconditionally.
  - oPIX_REQ=0 in all other modes.
- Colour bars (01): bar = x / (H_ACTIVE/8). Values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Gradient (10): pixel = {y[7:0], x[7:0]}.
- Frame-id (11): pixel = {8'hA5, oFRAME_CNT} using the value at frame start.
- iMODE changes mid-frame: no effect until the next frame start.

Test Plan:
- Bench params H_ACTIVE=8, V_ACTIVE=2, H_BLANK=3, VS_W=2, V_BP=2, V_FP=3.
  - Mode 01, iEN=1 -> frame length 2+2+32+3+3=42 cycles.
  - Line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
  - HREF high for 16 cycles, then low 3 cycles.
  - oFRAME_DONE on cycle 42; oFRAME_CNT=1.
- Mode 00, bench returns iPIX_DATA=16'h1234+pixel index on each oPIX_REQ -> line 0 bytes 12,34,12,35,...,12,3B; exactly 8 requests per line, first in the last VBP cycle.
- Mode 10 -> line 1, pixel 5 emits 01,05; DATA=00 during all HBLK cycles.
- Mode 11, iEN held 3 frames -> frame 2 pixels = A5,02; oFRAME_CNT reaches 3; VSYNC re-rises the cycle after each oFRAME_DONE.
- iEN dropped mid-ACT of frame 0 -> frame finishes (full 42 cycles); IDLE afterwards with oBUSY=0 and all outputs low.
- iRST_N pulsed low in HBLK -> VSYNC/HREF/DATA/oFRAME_CNT=0 immediately; restart after release gives a full frame starting with VS.
